stack_calc_ctrl: RTL and testbench

Command sequencer for the stack calculator datapath. It samples the debounced push-buttons and the 8-bit switch bank, decodes button combinations into stack operations, and drives a single-port synchronous stack RAM. It owns the stack pointer (SPR), display address (DAR) and display value (DVR) registers, which Top forwards to the seven-segment driver and LEDs.

---
 rtl/stack_calc_pkg.sv | 41 ++++
 rtl/stack_calc_ctrl_btn_cmd_capture.sv | 84 ++++++++
 rtl/stack_calc_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_stack_calc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_calc_pkg.sv
// Shared opcodes, state encodings and stack geometry for the stack calculator.
package stack_calc_pkg;

  localparam int unsigned PKG_AW = 7;

  function automatic int unsigned stack_max(input int unsigned aw);
    return (1 << aw) - 1;
  endfunction

  // Highest RAM address; also the stack pointer value of an empty stack.
  localparam int unsigned MAX = stack_max(PKG_AW);

  // Button patterns {Left, Right, Down, Up}.
  localparam logic [3:0] OP_PUSH  = 4'b0001;
  localparam logic [3:0] OP_POP   = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_TOP   = 4'b1001;
  localparam logic [3:0] OP_INC   = 4'b1101;
  localparam logic [3:0] OP_DEC   = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECODE,
    ST_RD_A,
    ST_RD_B,
    ST_EXEC,
    ST_SHOW,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_SETTLE,
    CAP_HOLD,
    CAP_RELEASE
  } cap_state_t;

endpackage

// File: rtl/stack_calc_ctrl_btn_cmd_capture.sv
// Button front end: waits for a pattern to stay stable, issues it once,
// then holds off until the sequencer finishes and all buttons are released.
module btn_cmd_capture
  import stack_calc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_btn,
  input  logic       i_done,
  output logic       o_cmd_valid,
  output logic [3:0] o_cmd,
  output logic       o_settling,
  output logic       o_busy
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  cap_state_t    r_state, w_next;
  logic [3:0]    r_pat;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          w_fire;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= CAP_IDLE;
    else       r_state <= w_next;
  end

  // Next state; fire once the pattern has been stable for SETTLE_CYC cycles.
  always_comb begin
    w_next = r_state;
    w_fire = 1'b0;
    unique case (r_state)
      CAP_IDLE:    if (i_btn != '0) w_next = CAP_SETTLE;
      CAP_SETTLE: begin
        if (i_btn == '0) begin
          w_next = CAP_IDLE;
        end else if (i_btn == r_pat && r_cnt == LAST) begin
          w_next = CAP_HOLD;
          w_fire = 1'b1;
        end
      end
      CAP_HOLD:    if (i_done) w_next = CAP_RELEASE;
      CAP_RELEASE: if (i_btn == '0) w_next = CAP_IDLE;
      default:     w_next = CAP_IDLE;
    endcase
  end

  // Pattern latch, settle counter and the one-cycle command strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pat   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_fire;
      case (r_state)
        CAP_IDLE: begin
          r_pat <= i_btn;
          r_cnt <= '0;
        end
        CAP_SETTLE: begin
          if (i_btn != r_pat) begin
            r_pat <= i_btn;
            r_cnt <= '0;
          end else if (!w_fire) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_valid = r_valid;
  assign o_cmd       = r_pat;
  assign o_settling  = (r_state == CAP_SETTLE);
  assign o_busy      = (r_state != CAP_IDLE);

endmodule

// File: rtl/stack_calc_ctrl.sv
// Stack calculator command sequencer: decodes button commands and drives the
// single-port synchronous stack RAM, owning SPR/DAR/DVR.
module stack_calc_ctrl
  import stack_calc_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = PKG_AW,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [3:0]    BTN,
  input  logic [DW-1:0] SW,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] SPR,
  output logic [AW-1:0] DAR,
  output logic [DW-1:0] DVR,
  output logic          EMPTY,
  output logic          FULL,
  output logic          ERR,
  output logic          BUSY
);

  localparam logic [AW-1:0] MAX_IDX = AW'(stack_max(AW));
  localparam logic [AW:0]   ONE_W   = 1;

  state_t        r_state, w_next;
  logic [AW-1:0] r_spr, r_dar;
  logic [DW-1:0] r_dvr, r_top;
  logic          r_err, r_pop_pend;

  logic          w_cmd_valid, w_cap_settling, w_cap_busy, w_done;
  logic [3:0]    w_cmd;
  logic [AW-1:0] w_spr_p1, w_spr_p2;
  logic          w_empty, w_full, w_two, w_last, w_inc_ok, w_dec_ok, w_reject;
  logic [DW-1:0] w_result;

  btn_cmd_capture #(.SETTLE_CYC(SETTLE_CYC)) u_cap (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_btn       (BTN),
    .i_done      (w_done),
    .o_cmd_valid (w_cmd_valid),
    .o_cmd       (w_cmd),
    .o_settling  (w_cap_settling),
    .o_busy      (w_cap_busy)
  );

  assign w_spr_p1 = r_spr + AW'(1);
  assign w_spr_p2 = r_spr + AW'(2);
  assign w_empty  = (r_spr == MAX_IDX);
  assign w_full   = (r_spr == '0);
  assign w_two    = (r_spr <= MAX_IDX - AW'(2));
  assign w_last   = (r_spr == MAX_IDX - AW'(1));
  assign w_inc_ok = (r_dar < MAX_IDX) && !w_empty;
  // Widened so an empty stack (SPR+1 past MAX) never lets DEC through.
  assign w_dec_ok = ({1'b0, r_dar} > ({1'b0, r_spr} + ONE_W));
  assign w_result = (w_cmd == OP_SUB) ? (mem_rdata - r_top) : (mem_rdata + r_top);
  assign w_reject = ((w_cmd == OP_PUSH) && w_full) ||
                    ((w_cmd == OP_POP) && w_empty) ||
                    (((w_cmd == OP_ADD) || (w_cmd == OP_SUB)) && !w_two);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and RAM port drive; at most one access per cycle.
  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_valid)         w_next = ST_DECODE;
        else if (w_cap_settling) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_cmd_valid)          w_next = ST_DECODE;
        else if (!w_cap_settling) w_next = ST_IDLE;
      end
      ST_DECODE: begin
        w_next = ST_RELEASE;
        case (w_cmd)
          OP_PUSH: begin
            if (!w_full) begin
              mem_addr  = r_spr;
              mem_wdata = SW;
              mem_we    = 1'b1;
            end
          end
          // POP reads the new top here and clears the vacated slot in SHOW,
          // so the display value lands on the same cycle as TOP.
          OP_POP: begin
            if (!w_empty) begin
              if (!w_last) mem_addr = w_spr_p2;
              w_next = ST_SHOW;
            end
          end
          OP_ADD, OP_SUB: if (w_two) w_next = ST_RD_A;
          OP_TOP: begin
            if (!w_empty) begin
              mem_addr = w_spr_p1;
              w_next   = ST_SHOW;
            end
          end
          OP_INC: begin
            if (w_inc_ok) begin
              mem_addr = r_dar + AW'(1);
              w_next   = ST_SHOW;
            end
          end
          OP_DEC: begin
            if (w_dec_ok) begin
              mem_addr = r_dar - AW'(1);
              w_next   = ST_SHOW;
            end
          end
          default: ;
        endcase
      end
      ST_RD_A: begin
        mem_addr = w_spr_p1;
        w_next   = ST_RD_B;
      end
      ST_RD_B: begin
        mem_addr = w_spr_p2;
        w_next   = ST_EXEC;
      end
      ST_EXEC: begin
        mem_addr  = w_spr_p2;
        mem_wdata = w_result;
        mem_we    = 1'b1;
        w_next    = ST_RELEASE;
      end
      ST_SHOW: begin
        if (r_pop_pend) begin
          mem_addr = r_spr;
          mem_we   = 1'b1;
        end else begin
          mem_addr = r_dar;
        end
        w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Architectural registers: SPR, DAR, DVR, ERR and operand holding.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_spr      <= MAX_IDX;
      r_dar      <= '0;
      r_dvr      <= '0;
      r_err      <= 1'b0;
      r_top      <= '0;
      r_pop_pend <= 1'b0;
    end else begin
      unique case (r_state)
        ST_DECODE: begin
          r_err      <= w_reject;
          r_pop_pend <= 1'b0;
          case (w_cmd)
            OP_PUSH: begin
              if (!w_full) begin
                r_spr <= r_spr - AW'(1);
                r_dar <= r_spr;
                r_dvr <= SW;
              end
            end
            OP_POP: begin
              if (!w_empty) begin
                r_spr      <= w_spr_p1;
                r_pop_pend <= 1'b1;
                r_dar      <= w_last ? '0 : w_spr_p2;
                if (w_last) r_dvr <= '0;
              end
            end
            OP_CLEAR: begin
              r_spr <= MAX_IDX;
              r_dar <= '0;
              r_dvr <= '0;
            end
            OP_TOP: begin
              r_dar <= w_spr_p1;
              if (w_empty) r_dvr <= '0;
            end
            OP_INC: if (w_inc_ok) r_dar <= r_dar + AW'(1);
            OP_DEC: if (w_dec_ok) r_dar <= r_dar - AW'(1);
            default: ;
          endcase
        end
        ST_RD_B: r_top <= mem_rdata;
        ST_EXEC: begin
          r_spr <= w_spr_p1;
          r_dar <= w_spr_p2;
          r_dvr <= w_result;
        end
        ST_SHOW: begin
          r_dvr      <= (r_pop_pend && w_empty) ? '0 : mem_rdata;
          r_pop_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign SPR   = r_spr;
  assign DAR   = r_dar;
  assign DVR   = r_dvr;
  assign ERR   = r_err;
  assign EMPTY = w_empty;
  assign FULL  = w_full;
  assign BUSY  = (r_state != ST_IDLE) || w_cap_busy;

endmodule

// File: tb/tb_stack_calc_ctrl.sv
// Scoreboard bench for stack_calc_ctrl with a behavioural stack model.
module tb_stack_calc_ctrl;
  import stack_calc_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] BTN = 4'b0000;
  logic [7:0] SW = 8'd0;
  logic [6:0] mem_addr, SPR, DAR;
  logic [7:0] mem_wdata, mem_rdata, DVR;
  logic       mem_we, EMPTY, FULL, ERR, BUSY;

  always #5 CLK = ~CLK;

  stack_calc_ctrl #(.DW(8), .AW(7), .SETTLE_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET), .BTN(BTN), .SW(SW),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .SPR(SPR), .DAR(DAR), .DVR(DVR), .EMPTY(EMPTY), .FULL(FULL), .ERR(ERR), .BUSY(BUSY)
  );

  typedef struct packed {
    logic [6:0]    spr;
    logic [6:0]    dar;
    logic [7:0]    dvr;
    logic          err;
    logic [7:0]    nwr;
    logic [1023:0] img;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  logic       prev_busy = 1'b0;

  // Reference model state: stack values (bottom first) and expected RAM image.
  logic [7:0] mdl_mem [0:127];
  logic [7:0] stk[$];
  int         m_dar = 0;
  logic [7:0] m_dvr = 8'd0;

  // RAM model: synchronous, read data valid one cycle after the address.
  logic [7:0] ram [0:127];
  logic       ram_load = 1'b1;
  always @(posedge CLK) begin
    if (ram_load) begin
      for (int i = 0; i < 128; i++) ram[i] <= mdl_mem[i];
      mem_rdata <= 8'd0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Compute the outcome of one command from the stack rules and queue it.
  task automatic model_cmd(input logic [3:0] pat, input logic [7:0] sw);
    exp_t e;
    int   n;
    int   nwr;
    logic err;
    logic [7:0] a, b, r;
    n = stk.size();
    nwr = 0;
    err = 1'b0;
    case (pat)
      OP_PUSH: begin
        if (n == int'(MAX)) err = 1'b1;
        else begin
          mdl_mem[127 - n] = sw;
          stk.push_back(sw);
          m_dar = 127 - n;
          m_dvr = sw;
          nwr = 1;
        end
      end
      OP_POP: begin
        if (n == 0) err = 1'b1;
        else begin
          mdl_mem[128 - n] = 8'd0;
          void'(stk.pop_back());
          nwr = 1;
          if (stk.size() == 0) begin m_dar = 0; m_dvr = 8'd0; end
          else begin m_dar = 128 - stk.size(); m_dvr = stk[stk.size() - 1]; end
        end
      end
      OP_ADD, OP_SUB: begin
        if (n < 2) err = 1'b1;
        else begin
          a = stk.pop_back();
          b = stk.pop_back();
          r = (pat == OP_ADD) ? b + a : b - a;
          stk.push_back(r);
          m_dar = 128 - stk.size();
          mdl_mem[m_dar] = r;
          m_dvr = r;
          nwr = 1;
        end
      end
      OP_CLEAR: begin stk.delete(); m_dar = 0; m_dvr = 8'd0; end
      OP_TOP: begin
        if (n == 0) begin m_dar = 0; m_dvr = 8'd0; end
        else begin m_dar = 128 - n; m_dvr = stk[n - 1]; end
      end
      OP_INC: if (m_dar < 127 && n > 0) begin m_dar++; m_dvr = stk[127 - m_dar]; end
      OP_DEC: if (m_dar > 128 - n) begin m_dar--; m_dvr = stk[127 - m_dar]; end
      default: ;
    endcase
    e.spr = 7'(127 - stk.size());
    e.dar = 7'(m_dar);
    e.dvr = m_dvr;
    e.err = err;
    e.nwr = 8'(nwr);
    for (int i = 0; i < 128; i++) e.img[i*8 +: 8] = mdl_mem[i];
    sb.push_back(e);
  endtask

  // Monitor: count RAM writes and check state each time a command completes.
  always @(negedge CLK) begin
    exp_t e;
    int bad;
    if (mem_we) begin
      wr_cnt++;
      check("wr_addr_nonzero", {31'd0, mem_addr != 7'd0}, 32'd1);
    end
    if (prev_busy && !BUSY) begin
      if (RESET) wr_cnt = 0;
      else if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_underflow: actual completion required none");
      end else begin
        e = sb.pop_front();
        check("spr", {25'd0, SPR}, {25'd0, e.spr});
        check("dar", {25'd0, DAR}, {25'd0, e.dar});
        check("dvr", {24'd0, DVR}, {24'd0, e.dvr});
        check("err", {31'd0, ERR}, {31'd0, e.err});
        check("empty", {31'd0, EMPTY}, {31'd0, e.spr == 7'd127});
        check("full", {31'd0, FULL}, {31'd0, e.spr == 7'd0});
        check("writes", wr_cnt, {24'd0, e.nwr});
        bad = -1;
        for (int i = 0; i < 128; i++) if (bad < 0 && ram[i] !== e.img[i*8 +: 8]) bad = i;
        n_chk++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL mem_image[%0d]: actual %0d required %0d", bad, ram[bad], e.img[bad*8 +: 8]);
        end
        wr_cnt = 0;
      end
    end
    prev_busy = BUSY;
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 300) begin @(negedge CLK); n++; end
    if (BUSY) begin
      n_chk++; n_fail++;
      $display("FAIL busy_timeout: actual BUSY=1 required 0");
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] pat, input logic [7:0] sw, input int hold);
    model_cmd(pat, sw);
    @(negedge CLK);
    SW = sw;
    BTN = pat;
    repeat (hold) @(negedge CLK);
    BTN = 4'b0000;
    wait_idle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_spr"}, {25'd0, SPR}, MAX);
    check({tag, "_dar"}, {25'd0, DAR}, 32'd0);
    check({tag, "_dvr"}, {24'd0, DVR}, 32'd0);
    check({tag, "_err"}, {31'd0, ERR}, 32'd0);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_empty"}, {31'd0, EMPTY}, 32'd1);
    check({tag, "_full"}, {31'd0, FULL}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, {25'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] others [7];
    int k;
    others = '{4'b0100, 4'b0111, 4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1111};
    for (int i = 0; i < 128; i++) mdl_mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    ram_load = 1'b0;
    check_reset_values("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Pushes; the first is held far longer than one command.
    press(OP_PUSH, 8'd69, 1000);
    press(OP_PUSH, 8'd42, 30);
    press(OP_PUSH, 8'd25, 30);
    press(OP_SUB, 8'd0, 30);
    press(OP_ADD, 8'd0, 30);
    press(OP_ADD, 8'd0, 30);
    // Subtract wrap, pops down to empty, underflow.
    press(OP_PUSH, 8'd5, 30);
    press(OP_PUSH, 8'd10, 30);
    press(OP_SUB, 8'd0, 30);
    press(OP_POP, 8'd0, 30);
    press(OP_POP, 8'd0, 30);
    press(OP_POP, 8'd0, 30);
    // Display address navigation.
    press(OP_PUSH, 8'd1, 30);
    press(OP_PUSH, 8'd2, 30);
    press(OP_PUSH, 8'd3, 30);
    repeat (3) press(OP_INC, 8'd0, 30);
    repeat (3) press(OP_DEC, 8'd0, 30);
    press(OP_INC, 8'd0, 30);
    press(OP_TOP, 8'd0, 30);
    press(OP_CLEAR, 8'd0, 30);
    press(OP_TOP, 8'd0, 30);
    press(OP_INC, 8'd0, 30);

    // Glitched combo: PUSH pattern briefly, then ADD held; only ADD runs.
    press(OP_PUSH, 8'd7, 30);
    press(OP_PUSH, 8'd8, 30);
    model_cmd(OP_ADD, 8'd99);
    @(negedge CLK);
    SW = 8'd99;
    BTN = OP_PUSH;
    repeat (5) @(negedge CLK);
    BTN = OP_ADD;
    repeat (30) @(negedge CLK);
    BTN = 4'b0000;
    wait_idle();

    // Reset while an ADD is in flight, before its result write.
    press(OP_PUSH, 8'd3, 30);
    press(OP_PUSH, 8'd4, 30);
    @(negedge CLK);
    BTN = OP_ADD;
    repeat (18) @(negedge CLK);
    RESET = 1'b1;
    BTN = 4'b0000;
    @(negedge CLK);
    check_reset_values("abort");
    @(negedge CLK);
    RESET = 1'b0;
    stk.delete();
    m_dar = 0;
    m_dvr = 8'd0;
    repeat (2) @(negedge CLK);
    press(OP_TOP, 8'd0, 30);

    // Randomized command mix.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 10);
      case (k)
        0, 1, 2: press(OP_PUSH, 8'($urandom), $urandom_range(20, 60));
        3:       press(OP_POP, 8'($urandom), $urandom_range(20, 60));
        4:       press(OP_ADD, 8'($urandom), $urandom_range(20, 60));
        5:       press(OP_SUB, 8'($urandom), $urandom_range(20, 60));
        6:       press(OP_TOP, 8'($urandom), $urandom_range(20, 60));
        7:       press(OP_INC, 8'($urandom), $urandom_range(20, 60));
        8:       press(OP_DEC, 8'($urandom), $urandom_range(20, 60));
        9:       press(OP_CLEAR, 8'($urandom), $urandom_range(20, 60));
        default: press(others[$urandom_range(0, 6)], 8'($urandom), $urandom_range(20, 60));
      endcase
    end

    // Fill to capacity, then one overflow push.
    press(OP_CLEAR, 8'd0, 30);
    for (int i = 0; i < int'(MAX); i++) press(OP_PUSH, 8'($urandom), 20);
    press(OP_PUSH, 8'hA5, 20);

    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
